// File: rtl/mips_multicycle_control_if.sv
// Memory bus between the multicycle control FSM (master) and the memory side (slave).
// A read or write is requested by holding MemRead or MemWrite high. Waitrequest high means "not yet".
// The access completes on the first rising clk edge where the request is high and waitrequest is low.
interface mips_multicycle_control_if;
    logic       waitrequest;
    logic       MemRead;
    logic       MemWrite;
    logic [3:0] byteenable;

    modport master (input waitrequest, output MemRead, MemWrite, byteenable);
    modport slave  (output waitrequest, input MemRead, MemWrite, byteenable);
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS-I control FSM: fetch, decode, execute, memory and writeback sequencing.
// It also generates every datapath select, write enable and ALU operation code.
module mips_multicycle_control (
    input  logic                             clk,
    input  logic                             Rst,
    input  logic [31:0]                      Instr,
    input  logic                             stall,
    input  logic                             PCIs0,
    mips_multicycle_control_if.master        bus,
    output logic                             Active,
    output logic [2:0]                       State,
    output logic                             IrSel,
    output logic                             IorD,
    output logic                             ALUSrcA,
    output logic [1:0]                       ALUSrcB,
    output logic [4:0]                       ALUControl,
    output logic                             ALUSel,
    output logic                             IrWrite,
    output logic                             PCWrite,
    output logic                             RegWrite,
    output logic                             MemtoReg,
    output logic                             PCSrc,
    output logic                             RegDst,
    output logic                             Is_Jump,
    output logic                             OutLSB,
    output logic                             ExtSel,
    output logic                             BranchDelay
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_RALU, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_JR, C_MULDIV, C_MFHILO
    } iclass_t;

    localparam logic [4:0] ALU_ADD  = 5'd0,  ALU_SUB  = 5'd1,  ALU_AND  = 5'd2,  ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4,  ALU_NOR  = 5'd5,  ALU_SLT  = 5'd6,  ALU_SLTU = 5'd7;
    localparam logic [4:0] ALU_SLL  = 5'd8,  ALU_SRL  = 5'd9,  ALU_SRA  = 5'd10, ALU_SLLV = 5'd11;
    localparam logic [4:0] ALU_SRLV = 5'd12, ALU_SRAV = 5'd13, ALU_LUI  = 5'd14, ALU_MULT = 5'd15;
    localparam logic [4:0] ALU_MULTU = 5'd16, ALU_DIV = 5'd17, ALU_DIVU = 5'd18, ALU_MFHI = 5'd19;
    localparam logic [4:0] ALU_MFLO = 5'd20, ALU_MTHI = 5'd21, ALU_MTLO = 5'd22, ALU_EQ   = 5'd23;
    localparam logic [4:0] ALU_NE   = 5'd24, ALU_LEZ  = 5'd25, ALU_GTZ  = 5'd26, ALU_LTZ  = 5'd27;
    localparam logic [4:0] ALU_GEZ  = 5'd28;

    state_t      state_q, state_d;
    logic        active_q, active_d;
    logic        bd_q, bd_d;

    iclass_t     cls;
    logic [4:0]  dec_op;
    logic [1:0]  dec_srcb;
    logic        dec_ext;
    logic        dec_slt;
    logic        mem_read, mem_write;

    logic [5:0]  opcode, funct;
    logic [4:0]  rt;
    logic        unused_instr_bits;

    assign opcode = Instr[31:26];
    assign funct  = Instr[5:0];
    assign rt     = Instr[20:16];
    assign unused_instr_bits = ^{Instr[25:21], Instr[15:6]};

    // Instruction classification; anything not listed falls through as a NOP.
    always_comb begin
        cls      = C_NOP;
        dec_op   = ALU_ADD;
        dec_srcb = 2'b00;
        dec_ext  = 1'b0;
        dec_slt  = 1'b0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20, 6'h21: begin cls = C_RALU; dec_op = ALU_ADD;  end
                    6'h22, 6'h23: begin cls = C_RALU; dec_op = ALU_SUB;  end
                    6'h24: begin cls = C_RALU; dec_op = ALU_AND;  end
                    6'h25: begin cls = C_RALU; dec_op = ALU_OR;   end
                    6'h26: begin cls = C_RALU; dec_op = ALU_XOR;  end
                    6'h27: begin cls = C_RALU; dec_op = ALU_NOR;  end
                    6'h2A: begin cls = C_RALU; dec_op = ALU_SLT;  dec_slt = 1'b1; end
                    6'h2B: begin cls = C_RALU; dec_op = ALU_SLTU; dec_slt = 1'b1; end
                    6'h00: begin cls = C_RALU; dec_op = ALU_SLL;  end
                    6'h02: begin cls = C_RALU; dec_op = ALU_SRL;  end
                    6'h03: begin cls = C_RALU; dec_op = ALU_SRA;  end
                    6'h04: begin cls = C_RALU; dec_op = ALU_SLLV; end
                    6'h06: begin cls = C_RALU; dec_op = ALU_SRLV; end
                    6'h07: begin cls = C_RALU; dec_op = ALU_SRAV; end
                    6'h08: cls = C_JR;
                    6'h10: begin cls = C_MFHILO; dec_op = ALU_MFHI;  end
                    6'h12: begin cls = C_MFHILO; dec_op = ALU_MFLO;  end
                    6'h11: begin cls = C_MULDIV; dec_op = ALU_MTHI;  end
                    6'h13: begin cls = C_MULDIV; dec_op = ALU_MTLO;  end
                    6'h18: begin cls = C_MULDIV; dec_op = ALU_MULT;  end
                    6'h19: begin cls = C_MULDIV; dec_op = ALU_MULTU; end
                    6'h1A: begin cls = C_MULDIV; dec_op = ALU_DIV;   end
                    6'h1B: begin cls = C_MULDIV; dec_op = ALU_DIVU;  end
                    default: ;
                endcase
            end
            6'h01: begin
                if (rt == 5'd0)      begin cls = C_BRANCH; dec_op = ALU_LTZ; end
                else if (rt == 5'd1) begin cls = C_BRANCH; dec_op = ALU_GEZ; end
            end
            6'h02: cls = C_JUMP;
            6'h04: begin cls = C_BRANCH; dec_op = ALU_EQ;  end
            6'h05: begin cls = C_BRANCH; dec_op = ALU_NE;  end
            6'h06: begin cls = C_BRANCH; dec_op = ALU_LEZ; end
            6'h07: begin cls = C_BRANCH; dec_op = ALU_GTZ; end
            6'h09: begin cls = C_IALU; dec_op = ALU_ADD;  dec_ext = 1'b1; end
            6'h0A: begin cls = C_IALU; dec_op = ALU_SLT;  dec_ext = 1'b1; dec_slt = 1'b1; end
            6'h0B: begin cls = C_IALU; dec_op = ALU_SLTU; dec_ext = 1'b1; dec_slt = 1'b1; end
            6'h0C: begin cls = C_IALU; dec_op = ALU_AND; end
            6'h0D: begin cls = C_IALU; dec_op = ALU_OR;  end
            6'h0E: begin cls = C_IALU; dec_op = ALU_XOR; end
            6'h0F: begin cls = C_IALU; dec_op = ALU_LUI; end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin cls = C_LOAD; dec_ext = 1'b1; end
            6'h2B: begin cls = C_STORE; dec_ext = 1'b1; end
            default: ;
        endcase
        if (cls == C_IALU || cls == C_LOAD || cls == C_STORE) dec_srcb = 2'b10;
    end

    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        bd_d       = bd_q;
        IrSel      = 1'b0;
        IorD       = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        ALUSel     = 1'b0;
        IrWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemtoReg   = 1'b0;
        PCSrc      = 1'b0;
        RegDst     = 1'b0;
        Is_Jump    = 1'b0;
        OutLSB     = 1'b0;
        ExtSel     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        // Enables are gated by reset so an access cut short by Rst never writes anything.
        if (!Rst) begin
            case (state_q)
                S_FETCH: begin
                    if (PCIs0) begin
                        active_d = 1'b0;
                        state_d  = S_HALT;
                    end else begin
                        mem_read = 1'b1;
                        IrSel    = 1'b1;
                        ALUSrcB  = 2'b01;
                        if (!bus.waitrequest) begin
                            IrWrite = 1'b1;
                            PCWrite = 1'b1;
                            PCSrc   = bd_q;
                            bd_d    = 1'b0;
                            state_d = S_DECODE;
                        end
                    end
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    ExtSel  = 1'b1;
                    state_d = S_EXEC;
                end
                S_EXEC: begin
                    state_d = S_FETCH;
                    if (cls != C_NOP && cls != C_JUMP) begin
                        ALUSrcA    = 1'b1;
                        ALUSrcB    = dec_srcb;
                        ExtSel     = dec_ext;
                        ALUControl = dec_op;
                    end
                    case (cls)
                        C_RALU, C_IALU, C_MFHILO: state_d = S_WB;
                        C_LOAD, C_STORE:          state_d = S_MEM;
                        C_BRANCH, C_JR:           bd_d = 1'b1;
                        C_JUMP: begin
                            Is_Jump = 1'b1;
                            bd_d    = 1'b1;
                        end
                        C_MULDIV: if (stall) state_d = S_EXEC;
                        default: ;
                    endcase
                end
                S_MEM: begin
                    IorD      = 1'b1;
                    ALUSel    = 1'b1;
                    mem_read  = (cls == C_LOAD);
                    mem_write = (cls == C_STORE);
                    if (!bus.waitrequest) state_d = (cls == C_LOAD) ? S_WB : S_FETCH;
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    state_d  = S_FETCH;
                    if (cls == C_LOAD) begin
                        MemtoReg = 1'b1;
                    end else begin
                        // The result comes from the live ALU, so the execute-cycle operation is re-issued.
                        ALUSrcA    = 1'b1;
                        ALUSrcB    = dec_srcb;
                        ExtSel     = dec_ext;
                        ALUControl = dec_op;
                        RegDst     = (cls != C_IALU);
                        OutLSB     = dec_slt;
                    end
                end
                S_HALT: state_d = S_HALT;
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= S_FETCH;
            active_q <= 1'b1;
            bd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            bd_q     <= bd_d;
        end
    end

    assign State          = state_q;
    assign Active         = active_q;
    assign BranchDelay    = bd_q;
    assign bus.MemRead    = mem_read;
    assign bus.MemWrite   = mem_write;
    assign bus.byteenable = (mem_read || mem_write) ? 4'hF : 4'h0;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: each instruction is turned into a cycle-by-cycle schedule
// of inputs and expected control words, which is then played against the DUT.
module tb_mips_multicycle_control;

  typedef struct packed {
    logic [2:0] state;
    logic       active;
    logic       ir_sel;
    logic       iord;
    logic       src_a;
    logic [1:0] src_b;
    logic [4:0] alu;
    logic       alu_sel;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       pc_src;
    logic       reg_dst;
    logic       is_jump;
    logic       out_lsb;
    logic       ext_sel;
    logic [3:0] be;
    logic       bd;
  } ctl_t;

  localparam int CW = $bits(ctl_t);
  localparam int K_NOP = 0, K_RALU = 1, K_IALU = 2, K_LD = 3, K_ST = 4, K_BR = 5;
  localparam int K_J = 6, K_JR = 7, K_MD = 8, K_HILO = 9;

  typedef struct { int cls; int op; } info_t;

  logic        clk = 1'b0;
  logic        Rst = 1'b0;
  logic [31:0] Instr = 32'h0;
  logic        stall = 1'b0;
  logic        PCIs0 = 1'b0;
  logic        Active, IrSel, IorD, ALUSrcA, ALUSel, IrWrite, PCWrite, RegWrite;
  logic        MemtoReg, PCSrc, RegDst, Is_Jump, OutLSB, ExtSel, BranchDelay;
  logic [2:0]  State;
  logic [1:0]  ALUSrcB;
  logic [4:0]  ALUControl;

  mips_multicycle_control_if bus();

  mips_multicycle_control dut (
    .clk(clk), .Rst(Rst), .Instr(Instr), .stall(stall), .PCIs0(PCIs0), .bus(bus),
    .Active(Active), .State(State), .IrSel(IrSel), .IorD(IorD), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ALUSel(ALUSel), .IrWrite(IrWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .PCSrc(PCSrc),
    .RegDst(RegDst), .Is_Jump(Is_Jump), .OutLSB(OutLSB), .ExtSel(ExtSel),
    .BranchDelay(BranchDelay)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [CW-1:0] exp_q[$];
  logic [2:0]    stim_q[$];   // {waitrequest, stall, PCIs0}
  info_t r_tab[int];
  info_t i_tab[int];
  logic  m_bd = 1'b0;
  logic  m_active = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ctl_t observed();
    ctl_t o;
    o = '{state: State, active: Active, ir_sel: IrSel, iord: IorD, src_a: ALUSrcA,
          src_b: ALUSrcB, alu: ALUControl, alu_sel: ALUSel, ir_write: IrWrite,
          pc_write: PCWrite, reg_write: RegWrite, mem_write: bus.MemWrite,
          mem_read: bus.MemRead, mem_to_reg: MemtoReg, pc_src: PCSrc, reg_dst: RegDst,
          is_jump: Is_Jump, out_lsb: OutLSB, ext_sel: ExtSel, be: bus.byteenable,
          bd: BranchDelay};
    return o;
  endfunction

  function automatic ctl_t base(input int st);
    ctl_t c = '0;
    c.state  = 3'(st);
    c.active = m_active;
    c.bd     = m_bd;
    return c;
  endfunction

  function automatic info_t classify(input logic [31:0] ins);
    info_t r = '{K_NOP, 0};
    int opc = int'(ins[31:26]);
    if (opc == 0) begin
      if (r_tab.exists(int'(ins[5:0]))) r = r_tab[int'(ins[5:0])];
    end else if (opc == 1) begin
      if (ins[20:16] == 5'd0) r = '{K_BR, 27};
      else if (ins[20:16] == 5'd1) r = '{K_BR, 28};
    end else if (i_tab.exists(opc)) begin
      r = i_tab[opc];
    end
    return r;
  endfunction

  task automatic push(input ctl_t c, input logic wr, input logic st, input logic pz);
    exp_q.push_back(c);
    stim_q.push_back({wr, st, pz});
  endtask

  // Reference schedule for one instruction: fw/mw bus wait cycles, sv stall cycles.
  task automatic model_instr(input logic [31:0] ins, input int fw, input int mw, input int sv);
    info_t inf = classify(ins);
    ctl_t c, e, m, w;
    c = base(0); c.mem_read = 1; c.ir_sel = 1; c.src_b = 2'b01; c.be = 4'hF;
    for (int i = 0; i < fw; i++) push(c, 1, 0, 0);
    c.ir_write = 1; c.pc_write = 1; c.pc_src = m_bd;
    push(c, 0, 0, 0);
    m_bd = 1'b0;
    c = base(1); c.src_b = 2'b11; c.ext_sel = 1;
    push(c, 0, 0, 0);
    e = base(2);
    if (inf.cls inside {K_RALU, K_HILO, K_BR, K_JR, K_MD}) begin
      e.src_a = 1; e.alu = 5'(inf.op);
    end else if (inf.cls == K_IALU) begin
      e.src_a = 1; e.src_b = 2'b10; e.alu = 5'(inf.op); e.ext_sel = (inf.op inside {0, 6, 7});
    end else if (inf.cls inside {K_LD, K_ST}) begin
      e.src_a = 1; e.src_b = 2'b10; e.ext_sel = 1;
    end else if (inf.cls == K_J) begin
      e.is_jump = 1;
    end
    if (inf.cls == K_MD) for (int i = 0; i < sv; i++) push(e, 0, 1, 0);
    push(e, 0, 0, 0);
    if (inf.cls inside {K_BR, K_J, K_JR}) m_bd = 1'b1;
    if (inf.cls inside {K_LD, K_ST}) begin
      m = base(3); m.iord = 1; m.alu_sel = 1; m.be = 4'hF;
      m.mem_read = (inf.cls == K_LD); m.mem_write = (inf.cls == K_ST);
      for (int i = 0; i < mw; i++) push(m, 1, 0, 0);
      push(m, 0, 0, 0);
    end
    if (inf.cls == K_LD) begin
      w = base(4); w.reg_write = 1; w.mem_to_reg = 1;
      push(w, 0, 0, 0);
    end else if (inf.cls inside {K_RALU, K_HILO, K_IALU}) begin
      w = e; w.state = 3'd4; w.reg_write = 1;
      w.reg_dst = (inf.cls != K_IALU); w.out_lsb = (inf.op inside {6, 7});
      push(w, 0, 0, 0);
    end
  endtask

  // Plays at most max_n scheduled cycles; leftovers are discarded.
  task automatic run_queues(input logic [31:0] ins, input string tag, input int max_n);
    int n = 0;
    while (exp_q.size() > 0 && n < max_n) begin
      logic [CW-1:0] e = exp_q.pop_front();
      logic [2:0]    s = stim_q.pop_front();
      @(negedge clk);
      Instr = ins;
      bus.waitrequest = s[2]; stall = s[1]; PCIs0 = s[0];
      #1 check($sformatf("%s#%0d", tag, n), 64'(observed()), 64'(e));
      n++;
    end
    exp_q.delete();
    stim_q.delete();
  endtask

  task automatic reset_check(input string tag);
    ctl_t r;
    @(negedge clk);
    bus.waitrequest = 1'b1; stall = 1'b0; PCIs0 = 1'b0;
    Rst = 1'b1;
    m_bd = 1'b0; m_active = 1'b1;
    r = base(0);
    #1 check(tag, 64'(observed()), 64'(r));
    @(negedge clk);
    Rst = 1'b0;
  endtask

  task automatic do_instr(input logic [31:0] ins, input int fw, input int mw, input int sv);
    model_instr(ins, fw, mw, sv);
    run_queues(ins, $sformatf("i%h", ins), 1000);
  endtask

  initial begin
    r_tab[32'h20] = '{K_RALU, 0};  r_tab[32'h21] = '{K_RALU, 0};  r_tab[32'h22] = '{K_RALU, 1};
    r_tab[32'h23] = '{K_RALU, 1};  r_tab[32'h24] = '{K_RALU, 2};  r_tab[32'h25] = '{K_RALU, 3};
    r_tab[32'h26] = '{K_RALU, 4};  r_tab[32'h27] = '{K_RALU, 5};  r_tab[32'h2A] = '{K_RALU, 6};
    r_tab[32'h2B] = '{K_RALU, 7};  r_tab[32'h00] = '{K_RALU, 8};  r_tab[32'h02] = '{K_RALU, 9};
    r_tab[32'h03] = '{K_RALU, 10}; r_tab[32'h04] = '{K_RALU, 11}; r_tab[32'h06] = '{K_RALU, 12};
    r_tab[32'h07] = '{K_RALU, 13}; r_tab[32'h08] = '{K_JR, 0};    r_tab[32'h10] = '{K_HILO, 19};
    r_tab[32'h12] = '{K_HILO, 20}; r_tab[32'h11] = '{K_MD, 21};   r_tab[32'h13] = '{K_MD, 22};
    r_tab[32'h18] = '{K_MD, 15};   r_tab[32'h19] = '{K_MD, 16};   r_tab[32'h1A] = '{K_MD, 17};
    r_tab[32'h1B] = '{K_MD, 18};
    i_tab[32'h02] = '{K_J, 0};     i_tab[32'h04] = '{K_BR, 23};   i_tab[32'h05] = '{K_BR, 24};
    i_tab[32'h06] = '{K_BR, 25};   i_tab[32'h07] = '{K_BR, 26};   i_tab[32'h09] = '{K_IALU, 0};
    i_tab[32'h0A] = '{K_IALU, 6};  i_tab[32'h0B] = '{K_IALU, 7};  i_tab[32'h0C] = '{K_IALU, 2};
    i_tab[32'h0D] = '{K_IALU, 3};  i_tab[32'h0E] = '{K_IALU, 4};  i_tab[32'h0F] = '{K_IALU, 14};
    i_tab[32'h20] = '{K_LD, 0};    i_tab[32'h21] = '{K_LD, 0};    i_tab[32'h23] = '{K_LD, 0};
    i_tab[32'h24] = '{K_LD, 0};    i_tab[32'h25] = '{K_LD, 0};    i_tab[32'h2B] = '{K_ST, 0};

    bus.waitrequest = 1'b1;
    #2 Rst = 1'b1;
    repeat (2) @(negedge clk);
    reset_check("reset");

    do_instr(32'h00641021, 0, 0, 0);  // ADDU $2,$3,$4
    do_instr(32'h00641021, 3, 0, 0);  // same with a slow fetch
    do_instr(32'h8C020004, 0, 2, 0);  // LW
    do_instr(32'h10000002, 0, 0, 0);  // BEQ
    do_instr(32'h00641021, 1, 0, 0);  // fetch after the branch applies PCSrc
    do_instr(32'h0062001A, 0, 0, 5);  // DIV with a 5-cycle stall
    do_instr(32'h2862FFFF, 0, 0, 0);  // SLTI
    do_instr(32'h3C021234, 0, 0, 0);  // LUI
    do_instr(32'h08000010, 0, 0, 0);  // J
    do_instr(32'hAC020008, 1, 1, 0);  // SW
    do_instr(32'hFC000000, 0, 0, 0);  // unsupported opcode

    for (int k = 0; k < 200; k++) begin
      logic [31:0] ins = $urandom();
      case ($urandom_range(0, 3))
        0: begin ins[31:26] = 6'h00; ins[5:0] = 6'($urandom_range(0, 6'h2B)); end
        1: ins[31:26] = 6'($urandom_range(2, 6'h2B));
        2: begin ins[31:26] = 6'h01; ins[20:16] = 5'($urandom_range(0, 2)); end
        default: ;
      endcase
      do_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4));
    end

    // Reset while a store is stuck waiting on the bus.
    model_instr(32'hAC020004, 0, 3, 0);
    run_queues(32'hAC020004, "sw_cut", 4);
    reset_check("reset_mid_access");

    // JR $0 followed by a fetch at PC 0 halts the core.
    do_instr(32'h00000008, 0, 0, 0);
    begin
      ctl_t h;
      h = base(0);
      push(h, 0, 0, 1);
      m_active = 1'b0;
      h = base(7);
      for (int i = 0; i < 3; i++) push(h, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
      run_queues(32'h00000000, "halt", 1000);
    end
    reset_check("reset_after_halt");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
